// File: rtl/alu181_nibble_seq.sv
// alu181_nibble_seq: runs one W-bit operation through an external 4-bit
// 74181-style ALU slice, one nibble per clock, LSB nibble first, chaining
// the slice carry-out into the next slice carry-in.
// Build option: define ALU181_SEQ_ZERO_FLAG_EN to add the res_zero output.
module alu181_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [4*NIBBLES-1:0] cmd_a,
    input  logic [4*NIBBLES-1:0] cmd_b,
    input  logic [3:0]           cmd_s,
    input  logic                 cmd_m,
    input  logic                 cmd_cn,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [3:0]           alu_s,
    output logic                 alu_m,
    output logic                 alu_cn,
    input  logic [3:0]           alu_f,
    input  logic                 alu_cn4,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*NIBBLES-1:0] res_f,
`ifdef ALU181_SEQ_ZERO_FLAG_EN
    output logic                 res_zero,
`endif
    output logic                 res_carry
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [3:0]      s_q, s_d;
    logic            m_q, m_d, cn_q, cn_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    res_f_q, res_f_d;
    logic            res_carry_q, res_carry_d;
    logic            res_valid_q, res_valid_d;
`ifdef ALU181_SEQ_ZERO_FLAG_EN
    logic            zero_q, zero_d;
`endif

    // Next-state, operand latching and per-slice result assembly.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no path leaves a
        // combinational output unassigned and no latch is inferred.
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        m_d         = m_q;
        cn_d        = cn_q;
        carry_d     = carry_q;
        res_f_d     = res_f_q;
        res_carry_d = res_carry_q;
        res_valid_d = res_valid_q;
`ifdef ALU181_SEQ_ZERO_FLAG_EN
        zero_d      = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    s_d     = cmd_s;
                    m_d     = cmd_m;
                    cn_d    = cmd_cn;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_f_d[{k_q, 2'b00} +: 4] = alu_f;
                carry_d = alu_cn4;
                if (k_q == K_LAST) begin
                    res_carry_d = alu_cn4;
                    k_d         = '0;
                    state_d     = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                // First DONE cycle registers the flags; the result is then
                // held until the consumer takes it.
                if (!res_valid_q) begin
                    res_valid_d = 1'b1;
`ifdef ALU181_SEQ_ZERO_FLAG_EN
                    zero_d      = (res_f_q == '0);
`endif
                end else if (res_ready) begin
                    res_valid_d = 1'b0;
`ifdef ALU181_SEQ_ZERO_FLAG_EN
                    zero_d      = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; async reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            m_q         <= 1'b0;
            cn_q        <= 1'b0;
            carry_q     <= 1'b0;
            res_f_q     <= '0;
            res_carry_q <= 1'b0;
            res_valid_q <= 1'b0;
`ifdef ALU181_SEQ_ZERO_FLAG_EN
            zero_q      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            m_q         <= m_d;
            cn_q        <= cn_d;
            carry_q     <= carry_d;
            res_f_q     <= res_f_d;
            res_carry_q <= res_carry_d;
            res_valid_q <= res_valid_d;
`ifdef ALU181_SEQ_ZERO_FLAG_EN
            zero_q      <= zero_d;
`endif
        end
    end

    // Slice drive: active only in RUN, carry-in chained from the previous slice.
    always_comb begin
        alu_a  = 4'h0;
        alu_b  = 4'h0;
        alu_s  = 4'h0;
        alu_m  = 1'b0;
        alu_cn = 1'b0;
        if (state_q == RUN) begin
            alu_a  = a_q[{k_q, 2'b00} +: 4];
            alu_b  = b_q[{k_q, 2'b00} +: 4];
            alu_s  = s_q;
            alu_m  = m_q;
            alu_cn = (k_q == '0) ? cn_q : carry_q;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign res_valid = res_valid_q;
    assign res_f     = res_f_q;
    assign res_carry = res_carry_q;
`ifdef ALU181_SEQ_ZERO_FLAG_EN
    assign res_zero  = zero_q;
`endif

endmodule

// File: doc/alu181_nibble_seq.md
ALU181_NIBBLE_SEQ -- requirements
Module: alu181_nibble_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operation (operand width W = 4*NIBBLES).
REQ-002 SHALL have ports: clk  input  1  rising-edge clock.
REQ-003 SHALL have rst_n  input  1  reset; the block uses one clock; reset is asynchronous and active-low.
REQ-004 SHALL have cmd_valid  input  1  command offered; cmd_ready  output  1  command accepted when both high.
REQ-005 SHALL have cmd_a, cmd_b  input  W  operands; cmd_s  input  4  ALU select; cmd_m  input  1  mode; cmd_cn  input  1  initial carry-in.
REQ-006 SHALL have alu_a, alu_b  output  4  slice operands; alu_s  output  4; alu_m  output  1; alu_cn  output  1, all driving the 4-bit ALU.
REQ-007 SHALL have alu_f  input  4  ALU slice result; alu_cn4  input  1  ALU slice carry-out.
REQ-008 SHALL have res_valid  output  1; res_ready  input  1; res_f  output  W  assembled result; res_carry  output  1  final carry-out.

Function
REQ-009 SHALL implement states IDLE, RUN, DONE; cmd_ready = 1 only in IDLE.
REQ-010 SHALL, in IDLE on cmd_valid & cmd_ready, latch all cmd_* fields, clear slice index k to 0, enter RUN next cycle.
REQ-011 SHALL, in RUN, drive alu_a/alu_b with nibble k of latched operands (k=0 is bits 3:0), alu_s/alu_m with latched values.
REQ-012 SHALL drive alu_cn with latched cmd_cn for k=0 and with the registered alu_cn4 of slice k-1 for k>0.
REQ-013 SHALL, at each RUN clock edge, write alu_f into res_f nibble k and register alu_cn4; k increments by 1.
REQ-014 SHALL leave RUN after slice k=NIBBLES-1 and enter DONE; res_carry = alu_cn4 of last slice.
REQ-015 SHALL give latency: command accepted at edge 0, res_valid high after edge NIBBLES+1 (5 cycles for default).
REQ-016 SHALL hold res_valid, res_f, res_carry stable in DONE until res_ready is high, then return to IDLE next cycle.
REQ-017 SHALL ignore cmd_valid and cmd_* changes outside IDLE; latched values alone determine the result.
REQ-018 SHALL drive alu_a, alu_b, alu_s, alu_m, alu_cn to 0 in IDLE and DONE.
REQ-019 SHALL treat M=1 identically (carry still chained); the ALU decides carry relevance.
REQ-020 SHALL not accept a new command in the cycle res is consumed; acceptance earliest one cycle after DONE->IDLE.

Reset
REQ-021 SHALL, on rst_n low at any time (including mid-RUN), asynchronously force state IDLE, k=0, all latched fields, res_f, res_carry, res_valid and all alu_* outputs to 0.
REQ-022 SHALL present cmd_ready = 1 in the first cycle after rst_n deasserts; an aborted operation produces no result.

Configuration
REQ-023 SHALL support macro ALU181_SEQ_ZERO_FLAG_EN.
REQ-024 SHALL, with ALU181_SEQ_ZERO_FLAG_EN defined, add output res_zero (1 bit), registered, high in DONE iff res_f == 0, reset 0, cleared on leaving DONE.
REQ-025 SHALL, without the macro, have no res_zero port and no associated logic; all other behaviour identical.

Verification (bench ALU model: S=1001,M=0 -> F=A+B+cn, cn4=carry; S=1011,M=1 -> F=A&B, cn4=0)
REQ-026 SHALL cover add: a=0x1234, b=0x0FFF, s=1001, m=0, cn=0 -> res_f=0x2233, res_carry=0, res_valid 5 cycles after accept.
REQ-027 SHALL cover full carry ripple: a=0xFFFF, b=0x0001, cn=0 -> res_f=0x0000, res_carry=1, res_zero=1 (macro on); alu_cn=1 on slices 1..3.
REQ-028 SHALL cover logic mode: a=0xF0F0, b=0x3C3C, s=1011, m=1 -> res_f=0x3030, res_carry=0.
REQ-029 SHALL cover backpressure: res_ready low 3 cycles in DONE -> res_valid, res_f stable, cmd_ready=0; cmd_valid pulses ignored; IDLE one cycle after res_ready.
REQ-030 SHALL cover reset mid-RUN: rst_n low during slice k=2 -> all outputs 0 immediately; after release cmd_ready=1, no res_valid until a new command completes.
